// File: rtl/led_control_module.sv
// ============================================================================
// Module   : led_control_module
// Purpose  : Byte-stream opcode decoder driving LED enables and frame RAM writes.
// Revision : 1.0
// ============================================================================
`default_nettype none

module led_control_module #(
    parameter int BYTES_PER_PIXEL            = 2,
    parameter int PIXEL_HEIGHT               = 32,
    parameter int PIXEL_WIDTH                = 64,
    parameter int BRIGHTNESS_LEVELS          = 8,
    parameter int WATCHDOG_SIGNATURE_BITS    = 32,
    parameter logic [WATCHDOG_SIGNATURE_BITS-1:0] WATCHDOG_SIGNATURE_PATTERN = 32'h5A5A_A5A5,
    parameter int WATCHDOG_CONTROL_TICKS     = 1000000,
    parameter int _UNUSED                    = 0,
    parameter int DOUBLE_BUFFER              = 1,
    parameter int USE_WATCHDOG               = 1,
    parameter int DEBUGGER                   = 1,
    localparam int RW  = $clog2(PIXEL_HEIGHT),
    localparam int CW  = $clog2(PIXEL_WIDTH),
    localparam int BW  = $clog2(BYTES_PER_PIXEL),
    localparam int DBW = (DOUBLE_BUFFER != 0) ? 1 : 0,
    localparam int AW  = DBW + RW + CW + BW
) (
    input  logic                         clk_in,
    input  logic                         reset,
    input  logic [7:0]                   data_rx,
    input  logic                         data_ready_n,
    output logic                         busy,
    output logic                         ready_for_data,
    output logic [2:0]                   rgb_enable,
    output logic [BRIGHTNESS_LEVELS-1:0] brightness_enable,
    output logic [7:0]                   ram_data_out,
    output logic [AW-1:0]                ram_address,
    output logic                         ram_write_enable,
    output logic                         ram_clk_enable,
    output logic                         frame_select,
    output logic                         watchdog_reset,
    output logic [7:0]                   num_commands_processed
);

    localparam int RQ        = (RW > 0) ? RW : 1;
    localparam int CQ        = (CW > 0) ? CW : 1;
    localparam int BQ        = (BW > 0) ? BW : 1;
    localparam int SIGW      = WATCHDOG_SIGNATURE_BITS;
    localparam int SIG_BYTES = SIGW / 8;
    localparam int SCW       = (SIG_BYTES > 1) ? $clog2(SIG_BYTES) : 1;
    localparam int WD_RELOAD = WATCHDOG_CONTROL_TICKS + 0 * _UNUSED;
    localparam int WDW       = $clog2(WD_RELOAD + 1);

    localparam logic [7:0] OP_BRIGHT = 8'h62;
    localparam logic [7:0] OP_RGB    = 8'h52;
    localparam logic [7:0] OP_ROW    = 8'h4C;
    localparam logic [7:0] OP_WDOG   = 8'h57;
    localparam logic [7:0] OP_FRAME  = 8'h46;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_BRIGHT   = 3'd1,
        S_RGB      = 3'd2,
        S_ROW_SEL  = 3'd3,
        S_ROW_DATA = 3'd4,
        S_WDOG     = 3'd5
    } state_t;

    state_t                         state_q;
    logic                           strobe_prev_q;
    logic [RQ-1:0]                  row_q;
    logic [CQ-1:0]                  col_q;
    logic [BQ-1:0]                  byte_q;
    logic [SIGW-1:0]                sig_q;
    logic [SCW-1:0]                 sig_cnt_q;
    logic [2:0]                     rgb_q;
    logic [BRIGHTNESS_LEVELS-1:0]   bright_q;
    logic [7:0]                     ram_data_q;
    logic [AW-1:0]                  ram_addr_q;
    logic                           ram_we_q;
    logic                           frame_q;

    logic                           w_accept;
    logic [SIGW-1:0]                w_sig_next;
    logic                           w_sig_last;
    logic                           w_sig_match;
    logic                           w_row_last;
    logic                           w_frame_bit;
    logic [AW-1:0]                  w_wr_addr;
    logic                           w_cmd_done;

    assign w_accept    = data_ready_n & ~strobe_prev_q;
    assign w_sig_next  = (sig_q << 8) | SIGW'(data_rx);
    assign w_sig_last  = (sig_cnt_q == SCW'(SIG_BYTES - 1));
    assign w_sig_match = w_accept && (state_q == S_WDOG) && w_sig_last &&
                         (w_sig_next == WATCHDOG_SIGNATURE_PATTERN);
    assign w_row_last  = (col_q == '0) && (byte_q == '0);

    // Rows are written into the frame that is not being displayed.
    assign w_frame_bit = (DBW != 0) ? ~frame_q : 1'b0;
    assign w_wr_addr   = (AW'(w_frame_bit) << (RW + CW + BW)) |
                         (AW'(row_q)       << (CW + BW))      |
                         (AW'(col_q)       << BW)             |
                         AW'(byte_q);

    assign w_cmd_done = w_accept && (
                            ((state_q == S_IDLE) && (data_rx == OP_FRAME)) ||
                            (state_q == S_BRIGHT) ||
                            (state_q == S_RGB) ||
                            ((state_q == S_ROW_DATA) && w_row_last) ||
                            ((state_q == S_WDOG) && w_sig_last));

    always_ff @(posedge clk_in) begin
        if (reset) begin
            state_q       <= S_IDLE;
            strobe_prev_q <= 1'b1;
            row_q         <= '0;
            col_q         <= '0;
            byte_q        <= '0;
            sig_q         <= '0;
            sig_cnt_q     <= '0;
            rgb_q         <= 3'b111;
            bright_q      <= '1;
            ram_data_q    <= 8'h00;
            ram_addr_q    <= '0;
            ram_we_q      <= 1'b0;
            frame_q       <= 1'b0;
        end else begin
            strobe_prev_q <= data_ready_n;
            ram_we_q      <= 1'b0;
            if (w_accept) begin
                case (state_q)
                    S_IDLE: begin
                        case (data_rx)
                            OP_BRIGHT: state_q <= S_BRIGHT;
                            OP_RGB:    state_q <= S_RGB;
                            OP_ROW:    state_q <= S_ROW_SEL;
                            OP_WDOG: begin
                                state_q   <= S_WDOG;
                                sig_cnt_q <= '0;
                            end
                            OP_FRAME: begin
                                if (DBW != 0) begin
                                    frame_q <= ~frame_q;
                                end
                            end
                            default: ;
                        endcase
                    end
                    S_BRIGHT: begin
                        bright_q <= BRIGHTNESS_LEVELS'(data_rx);
                        state_q  <= S_IDLE;
                    end
                    S_RGB: begin
                        rgb_q   <= data_rx[2:0];
                        state_q <= S_IDLE;
                    end
                    S_ROW_SEL: begin
                        row_q   <= (RW > 0) ? RQ'(data_rx) : '0;
                        col_q   <= CQ'(PIXEL_WIDTH - 1);
                        byte_q  <= BQ'(BYTES_PER_PIXEL - 1);
                        state_q <= S_ROW_DATA;
                    end
                    S_ROW_DATA: begin
                        ram_data_q <= data_rx;
                        ram_addr_q <= w_wr_addr;
                        ram_we_q   <= 1'b1;
                        if (byte_q == '0) begin
                            byte_q <= BQ'(BYTES_PER_PIXEL - 1);
                            col_q  <= col_q - CQ'(1);
                        end else begin
                            byte_q <= byte_q - BQ'(1);
                        end
                        if (w_row_last) begin
                            state_q <= S_IDLE;
                        end
                    end
                    S_WDOG: begin
                        sig_q     <= w_sig_next;
                        sig_cnt_q <= sig_cnt_q + SCW'(1);
                        if (w_sig_last) begin
                            state_q <= S_IDLE;
                        end
                    end
                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end

    assign busy              = (state_q != S_IDLE);
    assign ready_for_data    = (state_q == S_IDLE);
    assign rgb_enable        = rgb_q;
    assign brightness_enable = bright_q;
    assign ram_data_out      = ram_data_q;
    assign ram_address       = ram_addr_q;
    assign ram_write_enable  = ram_we_q;
    assign ram_clk_enable    = ram_we_q;
    assign frame_select      = (DBW != 0) ? frame_q : 1'b0;

    generate
        if (USE_WATCHDOG != 0) begin : g_watchdog
            logic [WDW-1:0] wd_cnt_q;
            logic           wd_pulse_q;

            // A valid signature arriving in the expiry cycle wins: reload, no pulse.
            always_ff @(posedge clk_in) begin
                if (reset) begin
                    wd_cnt_q   <= WDW'(WD_RELOAD);
                    wd_pulse_q <= 1'b0;
                end else begin
                    wd_pulse_q <= 1'b0;
                    if (w_sig_match) begin
                        wd_cnt_q <= WDW'(WD_RELOAD);
                    end else if (wd_cnt_q <= WDW'(1)) begin
                        wd_cnt_q   <= WDW'(WD_RELOAD);
                        wd_pulse_q <= 1'b1;
                    end else begin
                        wd_cnt_q <= wd_cnt_q - WDW'(1);
                    end
                end
            end

            assign watchdog_reset = wd_pulse_q;
        end else begin : g_no_watchdog
            assign watchdog_reset = 1'b0;
        end

        if (DEBUGGER != 0) begin : g_debugger
            logic [7:0] cmd_cnt_q;

            always_ff @(posedge clk_in) begin
                if (reset) begin
                    cmd_cnt_q <= 8'h00;
                end else if (w_cmd_done) begin
                    cmd_cnt_q <= cmd_cnt_q + 8'h01;
                end
            end

            assign num_commands_processed = cmd_cnt_q;
        end else begin : g_no_debugger
            assign num_commands_processed = 8'h00;
        end
    endgenerate

endmodule

`default_nettype wire

// File: tb/tb_led_control_module.sv
// ============================================================================
// Module   : tb_led_control_module
// Purpose  : Self-checking bench for led_control_module.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_led_control_module;

    localparam int H   = 32;
    localparam int W   = 64;
    localparam int BPP = 2;
    localparam int T   = 500;
    localparam int AW  = 13;

    logic           clk_in = 1'b0;
    logic           reset  = 1'b1;
    logic [7:0]     data_rx = 8'h00;
    logic           data_ready_n = 1'b1;
    logic           busy;
    logic           ready_for_data;
    logic [2:0]     rgb_enable;
    logic [7:0]     brightness_enable;
    logic [7:0]     ram_data_out;
    logic [AW-1:0]  ram_address;
    logic           ram_write_enable;
    logic           ram_clk_enable;
    logic           frame_select;
    logic           watchdog_reset;
    logic [7:0]     num_commands_processed;

    led_control_module #(
        .BYTES_PER_PIXEL(BPP),
        .PIXEL_HEIGHT(H),
        .PIXEL_WIDTH(W),
        .BRIGHTNESS_LEVELS(8),
        .WATCHDOG_SIGNATURE_BITS(32),
        .WATCHDOG_SIGNATURE_PATTERN(32'h5A5A_A5A5),
        .WATCHDOG_CONTROL_TICKS(T),
        ._UNUSED(0),
        .DOUBLE_BUFFER(1),
        .USE_WATCHDOG(1),
        .DEBUGGER(1)
    ) dut (
        .clk_in(clk_in),
        .reset(reset),
        .data_rx(data_rx),
        .data_ready_n(data_ready_n),
        .busy(busy),
        .ready_for_data(ready_for_data),
        .rgb_enable(rgb_enable),
        .brightness_enable(brightness_enable),
        .ram_data_out(ram_data_out),
        .ram_address(ram_address),
        .ram_write_enable(ram_write_enable),
        .ram_clk_enable(ram_clk_enable),
        .frame_select(frame_select),
        .watchdog_reset(watchdog_reset),
        .num_commands_processed(num_commands_processed)
    );

    always #5 clk_in = ~clk_in;

    int n_tests = 0;
    int n_fail  = 0;

    // Write observer and pulse counters.
    logic [AW+7:0] act_q[$];
    int            clk_en_bad = 0;
    int            wd_pulses  = 0;
    always @(negedge clk_in) begin
        if (ram_write_enable) act_q.push_back({ram_address, ram_data_out});
        if (ram_clk_enable !== ram_write_enable) clk_en_bad++;
        if (watchdog_reset) wd_pulses++;
    end

    // Behavioural model: mode 0 idle, 1 bright, 2 rgb, 3 row select, 4 row data, 5 signature.
    int            m_mode, m_row, m_k, m_sig_n;
    logic [7:0]    m_bright;
    logic [2:0]    m_rgb;
    logic          m_frame;
    logic [7:0]    m_count;
    logic [AW+7:0] exp_q[$];

    function automatic void model_reset();
        m_mode = 0; m_row = 0; m_k = 0; m_sig_n = 0;
        m_bright = 8'hFF; m_rgb = 3'b111; m_frame = 1'b0; m_count = 8'h00;
        exp_q.delete();
    endfunction

    function automatic void model_byte(input logic [7:0] b);
        int pos, col, by, addr;
        case (m_mode)
            0: begin
                if (b == 8'h62) m_mode = 1;
                else if (b == 8'h52) m_mode = 2;
                else if (b == 8'h4C) m_mode = 3;
                else if (b == 8'h57) begin m_mode = 5; m_sig_n = 0; end
                else if (b == 8'h46) begin m_frame = ~m_frame; m_count++; end
            end
            1: begin m_bright = b; m_count++; m_mode = 0; end
            2: begin m_rgb = 3'(b % 8); m_count++; m_mode = 0; end
            3: begin m_row = b % H; m_k = 0; m_mode = 4; end
            4: begin
                pos  = W * BPP - 1 - m_k;
                col  = pos / BPP;
                by   = pos % BPP;
                addr = (((m_frame ? 0 : 1) * H + m_row) * W + col) * BPP + by;
                exp_q.push_back({AW'(addr), b});
                m_k++;
                if (m_k == W * BPP) begin m_count++; m_mode = 0; end
            end
            default: begin
                m_sig_n++;
                if (m_sig_n == 4) begin m_count++; m_mode = 0; end
            end
        endcase
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic send(input logic [7:0] b);
        model_byte(b);
        @(negedge clk_in);
        data_rx = b;
        data_ready_n = 1'b0;
        @(negedge clk_in);
        data_ready_n = 1'b1;
        @(negedge clk_in);
        @(negedge clk_in);
    endtask

    task automatic do_reset();
        @(negedge clk_in);
        reset = 1'b1;
        data_ready_n = 1'b1;
        repeat (3) @(negedge clk_in);
        reset = 1'b0;
        model_reset();
        act_q.delete();
    endtask

    task automatic check_state(input string tag);
        chk({tag, "_bright"}, brightness_enable, m_bright);
        chk({tag, "_rgb"}, rgb_enable, m_rgb);
        chk({tag, "_frame"}, frame_select, m_frame);
        chk({tag, "_count"}, num_commands_processed, m_count);
        chk({tag, "_busy"}, busy, (m_mode != 0));
        chk({tag, "_ready"}, ready_for_data, (m_mode == 0));
    endtask

    task automatic compare_writes(input string tag);
        int n;
        chk({tag, "_wr_count"}, act_q.size(), exp_q.size());
        n = (act_q.size() < exp_q.size()) ? act_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) chk({tag, "_wr_addr_data"}, act_q[i], exp_q[i]);
        act_q.delete();
        exp_q.delete();
    endtask

    typedef struct {
        logic [7:0] op;
        logic [7:0] arg;
        logic [7:0] exp_bright;
        logic [2:0] exp_rgb;
    } vec_t;

    vec_t vecs[6];

    initial begin
        logic [AW+7:0] w;
        int bad_row;
        int pulse_pos[$];
        int wd_before;
        logic [7:0] b;
        int r;

        vecs[0] = '{8'h62, 8'h72, 8'h72, 3'b111};
        vecs[1] = '{8'h52, 8'h20, 8'h72, 3'b000};
        vecs[2] = '{8'h52, 8'h05, 8'h72, 3'b101};
        vecs[3] = '{8'h62, 8'hFF, 8'hFF, 3'b101};
        vecs[4] = '{8'h52, 8'hFA, 8'hFF, 3'b010};
        vecs[5] = '{8'h62, 8'h00, 8'h00, 3'b010};

        // Reset values
        do_reset();
        @(negedge clk_in);
        chk("rst_busy", busy, 1'b0);
        chk("rst_ready", ready_for_data, 1'b1);
        chk("rst_rgb", rgb_enable, 3'b111);
        chk("rst_bright", brightness_enable, 8'hFF);
        chk("rst_ram_data", ram_data_out, 8'h00);
        chk("rst_ram_addr", ram_address, 13'h0);
        chk("rst_we", ram_write_enable, 1'b0);
        chk("rst_clk_en", ram_clk_enable, 1'b0);
        chk("rst_frame", frame_select, 1'b0);
        chk("rst_wdr", watchdog_reset, 1'b0);
        chk("rst_count", num_commands_processed, 8'h00);

        // Two-byte commands from the table
        for (int i = 0; i < 6; i++) begin
            send(vecs[i].op);
            chk("vec_busy_mid", busy, 1'b1);
            chk("vec_ready_mid", ready_for_data, 1'b0);
            send(vecs[i].arg);
            chk("vec_bright", brightness_enable, vecs[i].exp_bright);
            chk("vec_rgb", rgb_enable, vecs[i].exp_rgb);
            chk("vec_busy_end", busy, 1'b0);
            chk("vec_count", num_commands_processed, 8'(i + 1));
        end
        send(8'h00);
        chk("ignored_count", num_commands_processed, 8'd6);
        chk("ignored_ready", ready_for_data, 1'b1);

        // Full stream "brR L-" plus one row
        do_reset();
        send(8'h62); send(8'h72); send(8'h52); send(8'h20); send(8'h4C); send(8'h2D);
        chk("row_busy", busy, 1'b1);
        for (int i = 0; i < W * BPP; i++) send(8'($urandom));
        chk("stream_bright", brightness_enable, 8'h72);
        chk("stream_rgb", rgb_enable, 3'b000);
        chk("stream_count", num_commands_processed, 8'd3);
        chk("stream_busy", busy, 1'b0);
        chk("stream_wr_total", act_q.size(), W * BPP);
        if (act_q.size() == W * BPP) begin
            w = act_q[0];
            chk("row_first_addr", w[AW+7:8], 13'd5887);
            w = act_q[W * BPP - 1];
            chk("row_last_addr", w[AW+7:8], 13'd5760);
            bad_row = 0;
            for (int i = 0; i < W * BPP; i++) begin
                w = act_q[i];
                if (((w[AW+7:8] >> 7) & 13'h1F) != 13'd13) bad_row++;
            end
            chk("row_all_13", bad_row, 0);
        end
        compare_writes("stream");

        // Frame toggle redirects the next row to the other frame
        send(8'h46);
        chk("frame_toggle", frame_select, 1'b1);
        chk("frame_count", num_commands_processed, 8'd4);
        send(8'h4C); send(8'h45);
        for (int i = 0; i < W * BPP; i++) send(8'($urandom));
        if (act_q.size() > 0) begin
            w = act_q[0];
            chk("frame0_first_addr", w[AW+7:8], 13'd767);
        end
        compare_writes("frame0");
        check_state("frame0");

        // Randomized stream against the model
        do_reset();
        for (int i = 0; i < 500 || m_mode != 0; i++) begin
            if (m_mode == 0) begin
                r = $urandom_range(0, 9);
                case (r)
                    0, 1:    b = 8'h62;
                    2, 3:    b = 8'h52;
                    4:       b = 8'h4C;
                    5:       b = 8'h57;
                    6:       b = 8'h46;
                    default: b = 8'($urandom);
                endcase
            end else begin
                b = 8'($urandom);
            end
            send(b);
            check_state("rand");
            if (i > 3000) break;
        end
        compare_writes("rand");

        // Reset during a row write
        do_reset();
        send(8'h4C); send(8'h2D);
        for (int i = 0; i < 10; i++) send(8'(i + 1));
        chk("midrst_writes", act_q.size(), 10);
        @(negedge clk_in);
        reset = 1'b1;
        data_rx = 8'h99;
        data_ready_n = 1'b0;
        @(negedge clk_in);
        data_ready_n = 1'b1;
        repeat (2) @(negedge clk_in);
        reset = 1'b0;
        model_reset();
        act_q.delete();
        repeat (20) @(negedge clk_in);
        chk("midrst_no_writes", act_q.size(), 0);
        chk("midrst_busy", busy, 1'b0);
        chk("midrst_ready", ready_for_data, 1'b1);
        send(8'h4C); send(8'h05); send(8'hC3);
        chk("restart_wr_count", act_q.size(), 1);
        if (act_q.size() > 0) begin
            w = act_q[0];
            chk("restart_addr", w[AW+7:8], 13'd4863);
        end
        for (int i = 1; i < W * BPP; i++) send(8'($urandom));
        compare_writes("restart");

        // Watchdog with no signature: pulses at T, 2T, 3T cycles after reset
        do_reset();
        for (int n = 1; n <= 3 * T + 5; n++) begin
            @(negedge clk_in);
            if (watchdog_reset) pulse_pos.push_back(n);
        end
        chk("wd_pulse_count", pulse_pos.size(), 3);
        if (pulse_pos.size() >= 2) begin
            chk("wd_first_pos", pulse_pos[0], T);
            chk("wd_period", pulse_pos[1] - pulse_pos[0], T);
        end

        // Correct signatures keep the watchdog quiet
        do_reset();
        wd_before = wd_pulses;
        for (int k = 0; k < 8; k++) begin
            send(8'h57); send(8'h5A); send(8'h5A); send(8'hA5); send(8'hA5);
            repeat (180) @(negedge clk_in);
        end
        chk("wd_good_sig_pulses", wd_pulses - wd_before, 0);
        chk("wd_good_sig_count", num_commands_processed, 8'd8);

        // Wrong signature does not reload
        do_reset();
        wd_before = wd_pulses;
        send(8'h57); send(8'h5A); send(8'h5A); send(8'hA5); send(8'hA4);
        repeat (T) @(negedge clk_in);
        chk("wd_bad_sig_pulses", wd_pulses - wd_before, 1);
        chk("wd_bad_sig_ready", ready_for_data, 1'b1);

        chk("clk_en_equals_we", clk_en_bad, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
